// File: rtl/pin_enroll.sv
`default_nettype none
// ============================================================================
// Module   : pin_enroll
// Purpose  : Writer side of the PIN path. Captures a new DIGITS-long decimal
//            PIN from two synchronized wallet buttons and commits it as a
//            packed BCD vector read by the PIN comparator as its stored PIN.
//            The first digit entered lands in bits [3:0], the next in [7:4].
// Ports    : clk_i       - system clock
//            rst_i       - synchronous reset, active-high
//            start_i     - level, starts/restarts enrollment
//            b_dir_i     - right button (rise = increment selected digit)
//            b_esq_i     - left button  (rise = accept selected digit)
//            pin_vec_o   - committed PIN, packed BCD
//            pin_valid_o - a PIN has been committed since reset
//            digit_o     - digit currently selected
//            pos_o       - index of the digit being entered
//            busy_o      - enrollment in progress (state != IDLE)
//            done_o      - one-cycle pulse on commit
//            err_o       - one-cycle pulse on confirm mismatch
// Option   : PIN_CONFIRM_EN - when defined, the PIN must be entered twice
//            and only a matching second entry is committed. When undefined
//            the confirm pass is absent and err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pin_enroll #(
  parameter int DIGITS    = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        b_dir_i,
  input  logic                        b_esq_i,
  output logic [4*DIGITS-1:0]         pin_vec_o,
  output logic                        pin_valid_o,
  output logic [3:0]                  digit_o,
  output logic [$clog2(DIGITS)-1:0]   pos_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o
);

  localparam int            PW        = $clog2(DIGITS);
  localparam logic [PW-1:0] POS_LAST  = PW'(DIGITS - 1);
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [3:0]    DIGIT_MAX = 4'(MAX_DIGIT);

`ifdef PIN_CONFIRM_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    CONFIRM = 2'd2,
    COMMIT  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTER   = 2'd1,
    COMMIT  = 2'd3
  } state_t;
`endif

  state_t                state_q, state_d;
  logic                  dir_prev_q, dir_prev_d;
  logic                  esq_prev_q, esq_prev_d;
  logic [3:0]            digit_q, digit_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   pin_vec_q, pin_vec_d;
  logic                  pin_valid_q, pin_valid_d;
  logic                  done_q, done_d;

  logic dir_rise, esq_rise;
  logic dir_ev, esq_ev;

  // A simultaneous rise on both buttons is ambiguous, so neither counts.
  assign dir_rise = b_dir_i & ~dir_prev_q;
  assign esq_rise = b_esq_i & ~esq_prev_q;
  assign dir_ev   = dir_rise & ~esq_rise;
  assign esq_ev   = esq_rise & ~dir_rise;

`ifdef PIN_CONFIRM_EN
  logic       mism_q, mism_d;
  logic       err_q, err_d;
  logic [3:0] shadow_sel;

  // Nibble of the first-pass entry at the current position.
  always_comb begin
    shadow_sel = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (int'(pos_q) == i) shadow_sel = shadow_q[4*i +: 4];
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    dir_prev_d  = b_dir_i;
    esq_prev_d  = b_esq_i;
    digit_d     = digit_q;
    pos_d       = pos_q;
    shadow_d    = shadow_q;
    pin_vec_d   = pin_vec_q;
    pin_valid_d = pin_valid_q;
    done_d      = 1'b0;
`ifdef PIN_CONFIRM_EN
    mism_d      = mism_q;
    err_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d  = ENTER;
          digit_d  = 4'd0;
          pos_d    = '0;
          shadow_d = '0;
`ifdef PIN_CONFIRM_EN
          mism_d   = 1'b0;
`endif
        end
      end

      ENTER: begin
        if (start_i) begin
          digit_d  = 4'd0;
          pos_d    = '0;
          shadow_d = '0;
        end else if (dir_ev) begin
          digit_d = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
        end else if (esq_ev) begin
          for (int i = 0; i < DIGITS; i++) begin
            if (int'(pos_q) == i) shadow_d[4*i +: 4] = digit_q;
          end
          digit_d = 4'd0;
          if (pos_q == POS_LAST) begin
            pos_d = '0;
`ifdef PIN_CONFIRM_EN
            state_d = CONFIRM;
            mism_d  = 1'b0;
`else
            state_d = COMMIT;
`endif
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end
      end

`ifdef PIN_CONFIRM_EN
      CONFIRM: begin
        if (start_i) begin
          state_d  = ENTER;
          digit_d  = 4'd0;
          pos_d    = '0;
          shadow_d = '0;
          mism_d   = 1'b0;
        end else if (dir_ev) begin
          digit_d = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
        end else if (esq_ev) begin
          // Mismatches accumulate; the verdict is applied in COMMIT so the
          // error pulse has the same latency as the done pulse.
          mism_d  = mism_q | (digit_q != shadow_sel);
          digit_d = 4'd0;
          if (pos_q == POS_LAST) begin
            pos_d   = '0;
            state_d = COMMIT;
          end else begin
            pos_d = pos_q + POS_ONE;
          end
        end
      end
`endif

      COMMIT: begin
        // Single uninterruptible cycle; start_i is deliberately ignored.
        state_d = IDLE;
        digit_d = 4'd0;
        pos_d   = '0;
`ifdef PIN_CONFIRM_EN
        mism_d  = 1'b0;
        if (mism_q) begin
          err_d = 1'b1;
        end else begin
          pin_vec_d   = shadow_q;
          pin_valid_d = 1'b1;
          done_d      = 1'b1;
        end
`else
        pin_vec_d   = shadow_q;
        pin_valid_d = 1'b1;
        done_d      = 1'b1;
`endif
      end

      default: begin
        state_d = IDLE;
        digit_d = 4'd0;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      dir_prev_q  <= 1'b0;
      esq_prev_q  <= 1'b0;
      digit_q     <= 4'd0;
      pos_q       <= '0;
      shadow_q    <= '0;
      pin_vec_q   <= '0;
      pin_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef PIN_CONFIRM_EN
      mism_q      <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dir_prev_q  <= dir_prev_d;
      esq_prev_q  <= esq_prev_d;
      digit_q     <= digit_d;
      pos_q       <= pos_d;
      shadow_q    <= shadow_d;
      pin_vec_q   <= pin_vec_d;
      pin_valid_q <= pin_valid_d;
      done_q      <= done_d;
`ifdef PIN_CONFIRM_EN
      mism_q      <= mism_d;
      err_q       <= err_d;
`endif
    end
  end

  assign pin_vec_o   = pin_vec_q;
  assign pin_valid_o = pin_valid_q;
  assign digit_o     = digit_q;
  assign pos_o       = pos_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
`ifdef PIN_CONFIRM_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pin_enroll.sv
`default_nettype none
// ============================================================================
// Module   : tb_pin_enroll
// Purpose  : Directed self-checking bench for pin_enroll (DIGITS=4,
//            MAX_DIGIT=9). Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pin_enroll;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        b_dir_i;
  logic        b_esq_i;
  logic [15:0] pin_vec_o;
  logic        pin_valid_o;
  logic [3:0]  digit_o;
  logic [1:0]  pos_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int checks = 0;
  int fails  = 0;
  int done_cnt = 0;

  pin_enroll #(.DIGITS(4), .MAX_DIGIT(9)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .b_dir_i     (b_dir_i),
    .b_esq_i     (b_esq_i),
    .pin_vec_o   (pin_vec_o),
    .pin_valid_o (pin_valid_o),
    .digit_o     (digit_o),
    .pos_o       (pos_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (done_o === 1'b1) done_cnt++;

  // Advance one clock; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic press_dir();
    b_dir_i = 1'b1; tick();
    b_dir_i = 1'b0; tick();
  endtask

  task automatic press_esq();
    b_esq_i = 1'b1; tick();
    b_esq_i = 1'b0; tick();
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick();
    start_i = 1'b0;
  endtask

  task automatic enter_digit(input int d);
    for (int i = 0; i < d; i++) press_dir();
    press_esq();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; b_dir_i = 1'b0; b_esq_i = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pin_vec_o, pin_valid_o, digit_o, pos_o, busy_o, done_o, err_o} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got pin=%h valid=%b digit=%h pos=%0d busy=%b done=%b err=%b, expected all 0",
               pin_vec_o, pin_valid_o, digit_o, pos_o, busy_o, done_o, err_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_idle_ignores_buttons();
    press_dir();
    checks++;
    if (digit_o !== 4'd0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_buttons: got digit=%h busy=%b, expected digit=0 busy=0", digit_o, busy_o);
    end
  endtask

  task automatic test_basic_enroll();
    int cnt0;
    cnt0 = done_cnt;
    pulse_start();
    checks++;
    if (busy_o !== 1'b1 || pos_o !== 2'd0 || digit_o !== 4'd0) begin
      fails++;
      $display("FAIL start_enter: got busy=%b pos=%0d digit=%h, expected busy=1 pos=0 digit=0", busy_o, pos_o, digit_o);
    end
    press_dir();
    checks++;
    if (digit_o !== 4'd1) begin
      fails++;
      $display("FAIL dir_increment: got digit=%h, expected 1", digit_o);
    end
    press_esq();
    checks++;
    if (pos_o !== 2'd1 || digit_o !== 4'd0) begin
      fails++;
      $display("FAIL esq_accept: got pos=%0d digit=%h, expected pos=1 digit=0", pos_o, digit_o);
    end
    enter_digit(2);
    enter_digit(3);
    // Final accept: edge k registers the rise, edge k+1 commits.
    for (int i = 0; i < 4; i++) press_dir();
    b_esq_i = 1'b1; tick();
    checks++;
    if (done_o !== 1'b0 || pin_vec_o !== 16'h0000 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL commit_edge_k: got done=%b pin=%h busy=%b, expected done=0 pin=0000 busy=1", done_o, pin_vec_o, busy_o);
    end
    b_esq_i = 1'b0; tick();
    checks++;
    if (done_o !== 1'b1 || pin_vec_o !== 16'h4321 || pin_valid_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL commit_1234: got done=%b pin=%h valid=%b busy=%b, expected done=1 pin=4321 valid=1 busy=0",
               done_o, pin_vec_o, pin_valid_o, busy_o);
    end
    tick();
    checks++;
    if (done_o !== 1'b0 || done_cnt - cnt0 !== 1) begin
      fails++;
      $display("FAIL done_pulse: got done=%b pulses=%0d, expected done=0 pulses=1", done_o, done_cnt - cnt0);
    end
  endtask

  task automatic test_wrap();
    pulse_start();
    for (int i = 0; i < 9; i++) press_dir();
    checks++;
    if (digit_o !== 4'd9) begin
      fails++;
      $display("FAIL wrap_nine: got digit=%h, expected 9", digit_o);
    end
    press_dir();
    checks++;
    if (digit_o !== 4'd0) begin
      fails++;
      $display("FAIL wrap_zero: got digit=%h, expected 0", digit_o);
    end
    press_esq();
    enter_digit(1);
    enter_digit(2);
    enter_digit(3);
    checks++;
    if (pin_vec_o !== 16'h3210 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL wrap_commit: got pin=%h done=%b, expected pin=3210 done=1", pin_vec_o, done_o);
    end
  endtask

  task automatic test_restart();
    pulse_start();
    enter_digit(7);
    enter_digit(8);
    checks++;
    if (pos_o !== 2'd2 || pin_vec_o !== 16'h3210) begin
      fails++;
      $display("FAIL mid_entry: got pos=%0d pin=%h, expected pos=2 pin=3210", pos_o, pin_vec_o);
    end
    b_dir_i = 1'b1; start_i = 1'b1; tick();
    start_i = 1'b0; b_dir_i = 1'b0; tick();
    checks++;
    if (pos_o !== 2'd0 || digit_o !== 4'd0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL restart: got pos=%0d digit=%h busy=%b, expected pos=0 digit=0 busy=1", pos_o, digit_o, busy_o);
    end
    enter_digit(5);
    enter_digit(5);
    enter_digit(5);
    checks++;
    if (pin_vec_o !== 16'h3210) begin
      fails++;
      $display("FAIL pin_hold: got pin=%h, expected 3210", pin_vec_o);
    end
    enter_digit(5);
    checks++;
    if (pin_vec_o !== 16'h5555) begin
      fails++;
      $display("FAIL restart_commit: got pin=%h, expected 5555", pin_vec_o);
    end
  endtask

  task automatic test_commit_ignores_start();
    pulse_start();
    enter_digit(9);
    enter_digit(8);
    enter_digit(7);
    for (int i = 0; i < 6; i++) press_dir();
    b_esq_i = 1'b1; tick();
    b_esq_i = 1'b0; start_i = 1'b1; tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1 || pin_vec_o !== 16'h6789) begin
      fails++;
      $display("FAIL commit_start: got busy=%b done=%b pin=%h, expected busy=0 done=1 pin=6789", busy_o, done_o, pin_vec_o);
    end
    tick();
  endtask

  task automatic test_both_and_hold();
    pulse_start();
    b_dir_i = 1'b1; b_esq_i = 1'b1; tick();
    b_dir_i = 1'b0; b_esq_i = 1'b0; tick();
    checks++;
    if (digit_o !== 4'd0 || pos_o !== 2'd0) begin
      fails++;
      $display("FAIL both_rise: got digit=%h pos=%0d, expected digit=0 pos=0", digit_o, pos_o);
    end
    b_dir_i = 1'b1;
    repeat (20) tick();
    checks++;
    if (digit_o !== 4'd1) begin
      fails++;
      $display("FAIL hold_dir: got digit=%h, expected 1", digit_o);
    end
    b_dir_i = 1'b0; tick();
  endtask

  task automatic test_reset_mid();
    pulse_start();
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
    checks++;
    if (pin_vec_o !== 16'h4321) begin
      fails++;
      $display("FAIL recommit: got pin=%h, expected 4321", pin_vec_o);
    end
    pulse_start();
    enter_digit(1); enter_digit(2);
    rst_i = 1'b1; tick();
    rst_i = 1'b0;
    checks++;
    if (pin_vec_o !== 16'h0000 || pin_valid_o !== 1'b0 || busy_o !== 1'b0 || pos_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_mid: got pin=%h valid=%b busy=%b pos=%0d, expected pin=0000 valid=0 busy=0 pos=0",
               pin_vec_o, pin_valid_o, busy_o, pos_o);
    end
    tick();
  endtask

`ifdef PIN_CONFIRM_EN
  task automatic test_confirm();
    int cnt0;
    pulse_start();
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
    pulse_start();
    enter_digit(9); enter_digit(8); enter_digit(7); enter_digit(6);
    enter_digit(9); enter_digit(8); enter_digit(7); enter_digit(6);
    checks++;
    if (pin_vec_o !== 16'h6789 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL confirm_setup: got pin=%h done=%b, expected pin=6789 done=1", pin_vec_o, done_o);
    end
    tick();
    cnt0 = done_cnt;
    pulse_start();
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(5);
    checks++;
    if (err_o !== 1'b1 || done_cnt != cnt0 || pin_vec_o !== 16'h6789 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL confirm_mismatch: got err=%b pulses=%0d pin=%h busy=%b, expected err=1 pulses=0 pin=6789 busy=0",
               err_o, done_cnt - cnt0, pin_vec_o, busy_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: got err=%b, expected 0", err_o);
    end
    pulse_start();
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
    enter_digit(1); enter_digit(2); enter_digit(3); enter_digit(4);
    checks++;
    if (pin_vec_o !== 16'h4321 || done_o !== 1'b1 || err_o !== 1'b0) begin
      fails++;
      $display("FAIL confirm_match: got pin=%h done=%b err=%b, expected pin=4321 done=1 err=0", pin_vec_o, done_o, err_o);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignores_buttons();
`ifdef PIN_CONFIRM_EN
    test_confirm();
`else
    test_basic_enroll();
    test_wrap();
    test_restart();
    test_commit_ignores_start();
    test_both_and_hold();
    test_reset_mid();
    checks++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL err_tied: got err=%b, expected 0", err_o);
    end
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
